// File: rtl/fft_pkg.sv
// Shared types and width helpers for the FFT post-processing blocks.
package fft_pkg;

  typedef enum logic {
    PK_IDLE,
    PK_TRACK
  } pk_state_t;

  localparam int PWR_MULT = 2;

  function automatic int pwr_width(input int dw);
    return PWR_MULT * dw;
  endfunction

endpackage

// File: rtl/fft_cmag2.sv
// Two-stage pipelined squared magnitude re^2 + im^2 with a bin/last sideband.
module fft_cmag2
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BIN_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     vld_p0,
  input  logic signed [DATA_W-1:0] re_p0,
  input  logic signed [DATA_W-1:0] im_p0,
  input  logic [BIN_W-1:0]         bin_p0,
  input  logic                     last_p0,
  output logic                     vld_p2,
  output logic [pwr_width(DATA_W)-1:0] pwr_p2,
  output logic [BIN_W-1:0]         bin_p2,
  output logic                     last_p2
);

  localparam int PW = pwr_width(DATA_W);

  logic                 vld_p1;
  logic signed [PW-1:0] sq_re_p1;
  logic signed [PW-1:0] sq_im_p1;
  logic [BIN_W-1:0]     bin_p1;
  logic                 last_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (clr) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // p0 -> p1: squares; the product of two DATA_W values never exceeds PW bits
  always_ff @(posedge clk) begin
    if (en) begin
      sq_re_p1 <= PW'(re_p0) * PW'(re_p0);
      sq_im_p1 <= PW'(im_p0) * PW'(im_p0);
      bin_p1   <= bin_p0;
      last_p1  <= last_p0;
    end
  end

  // p1 -> p2: unsigned sum, max 2^(PW-1) so no carry out is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_p2  <= '0;
      bin_p2  <= '0;
      last_p2 <= 1'b0;
    end else if (en) begin
      pwr_p2  <= $unsigned(sq_re_p1) + $unsigned(sq_im_p1);
      bin_p2  <= bin_p1;
      last_p2 <= last_p1;
    end
  end

endmodule

// File: rtl/fft_power_peak.sv
// Bin power stream with per-frame peak search; holds the bin counter,
// the peak tracker and the valid/ready handshake around fft_cmag2.
module fft_power_peak
  import fft_pkg::*;
#(
  parameter int FFT_SIZE   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int SKIP_DC    = 1,
  localparam int LOG2      = $clog2(FFT_SIZE),
  localparam int PWR_W     = pwr_width(DATA_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    frame_clr_i,
  input  logic                    fft_in_valid_i,
  input  logic [2*DATA_WIDTH-1:0] fft_in_data_i,
  output logic                    fft_in_ready_o,
  output logic                    pwr_valid_o,
  output logic [PWR_W-1:0]        pwr_data_o,
  output logic [LOG2-1:0]         pwr_bin_o,
  output logic                    pwr_last_o,
  input  logic                    pwr_ready_i,
  output logic                    peak_valid_o,
  output logic [LOG2-1:0]         peak_bin_o,
  output logic [PWR_W-1:0]        peak_pwr_o
);

  localparam logic [LOG2-1:0] FIRST_BIN = (SKIP_DC != 0) ? LOG2'(1) : '0;
  localparam logic [LOG2-1:0] LAST_BIN  = LOG2'(FFT_SIZE - 1);

  logic            en;
  logic            in_hs;
  logic            out_hs;
  logic [LOG2-1:0] cnt;

  pk_state_t        pk_state;
  pk_state_t        pk_state_nxt;
  logic [LOG2-1:0]  trk_bin;
  logic [PWR_W-1:0] trk_pwr;
  logic [LOG2-1:0]  trk_bin_nxt;
  logic [PWR_W-1:0] trk_pwr_nxt;

  assign en             = !pwr_valid_o | pwr_ready_i;
  assign fft_in_ready_o = en & !frame_clr_i;
  assign in_hs          = fft_in_valid_i & fft_in_ready_o;
  assign out_hs         = pwr_valid_o & pwr_ready_i;

  fft_cmag2 #(
    .DATA_W (DATA_WIDTH),
    .BIN_W  (LOG2)
  ) u_cmag2 (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .en      (en),
    .clr     (frame_clr_i),
    .vld_p0  (in_hs),
    .re_p0   (fft_in_data_i[2*DATA_WIDTH-1:DATA_WIDTH]),
    .im_p0   (fft_in_data_i[DATA_WIDTH-1:0]),
    .bin_p0  (cnt),
    .last_p0 (cnt == LAST_BIN),
    .vld_p2  (pwr_valid_o),
    .pwr_p2  (pwr_data_o),
    .bin_p2  (pwr_bin_o),
    .last_p2 (pwr_last_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (frame_clr_i) begin
      cnt <= '0;
    end else if (in_hs) begin
      cnt <= cnt + LOG2'(1);
    end
  end

  // Until the first eligible bin loads, the stored value is meaningless,
  // so comparisons only start in PK_TRACK.
  always_comb begin
    trk_bin_nxt  = trk_bin;
    trk_pwr_nxt  = trk_pwr;
    pk_state_nxt = pk_state;
    if (pwr_bin_o == FIRST_BIN ||
        (pk_state == PK_TRACK && pwr_data_o > trk_pwr)) begin
      trk_bin_nxt  = pwr_bin_o;
      trk_pwr_nxt  = pwr_data_o;
      pk_state_nxt = PK_TRACK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pk_state     <= PK_IDLE;
      trk_bin      <= '0;
      trk_pwr      <= '0;
      peak_valid_o <= 1'b0;
      peak_bin_o   <= '0;
      peak_pwr_o   <= '0;
    end else if (frame_clr_i) begin
      pk_state     <= PK_IDLE;
      trk_bin      <= '0;
      trk_pwr      <= '0;
      peak_valid_o <= 1'b0;
    end else begin
      peak_valid_o <= out_hs & pwr_last_o;
      if (out_hs) begin
        trk_bin  <= trk_bin_nxt;
        trk_pwr  <= trk_pwr_nxt;
        pk_state <= pwr_last_o ? PK_IDLE : pk_state_nxt;
        if (pwr_last_o) begin
          peak_bin_o <= trk_bin_nxt;
          peak_pwr_o <= trk_pwr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_power_peak.sv
// Directed bench for fft_power_peak with a queue/array reference model.
module tb_fft_power_peak;

  localparam int N    = 16;
  localparam int DW   = 16;
  localparam int LOG2 = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic          pwr_valid;
  logic [31:0]   pwr_data;
  logic [LOG2-1:0] pwr_bin;
  logic          pwr_last;
  logic          pwr_ready = 1'b1;
  logic          peak_valid;
  logic [LOG2-1:0] peak_bin;
  logic [31:0]   peak_pwr;

  fft_power_peak #(.FFT_SIZE(N), .DATA_WIDTH(DW), .SKIP_DC(1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .frame_clr_i    (frame_clr),
    .fft_in_valid_i (in_valid),
    .fft_in_data_i  (in_data),
    .fft_in_ready_o (in_ready),
    .pwr_valid_o    (pwr_valid),
    .pwr_data_o     (pwr_data),
    .pwr_bin_o      (pwr_bin),
    .pwr_last_o     (pwr_last),
    .pwr_ready_i    (pwr_ready),
    .peak_valid_o   (peak_valid),
    .peak_bin_o     (peak_bin),
    .peak_pwr_o     (peak_pwr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: expected output queue plus per-frame power table
  typedef struct {
    logic [31:0] pwr;
    int          bin;
  } exp_t;

  exp_t        q[$];
  int          m_cnt = 0;
  logic [31:0] fr[N];
  bit          pk_pend = 0;
  int          pk_bin = 0;
  logic [31:0] pk_pwr = '0;
  bit          stalled = 0;
  logic [31:0] hold_data;
  logic [LOG2-1:0] hold_bin;
  logic        hold_last;

  function automatic int frame_argmax();
    int best = -1;
    for (int b = 1; b < N; b++)
      if (best < 0 || fr[b] > fr[best]) best = b;
    return best;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_cnt   = 0;
      pk_pend = 0;
      stalled = 0;
    end else begin
      if (pk_pend) begin
        check("peak_pulse", peak_valid, 1);
        check("peak_bin", peak_bin, pk_bin);
        check("peak_pwr", peak_pwr, pk_pwr);
      end else begin
        check("peak_idle", peak_valid, 0);
      end
      pk_pend = 0;
      if (stalled) begin
        check("stall_valid", pwr_valid, 1);
        check("stall_data", pwr_data, hold_data);
        check("stall_bin", pwr_bin, hold_bin);
        check("stall_last", pwr_last, hold_last);
      end
      if (pwr_valid) begin
        if (q.size() == 0) begin
          check("pwr_valid_unexpected", pwr_valid, 0);
        end else begin
          check("pwr_data", pwr_data, q[0].pwr);
          check("pwr_bin", pwr_bin, q[0].bin);
          check("pwr_last", pwr_last, q[0].bin == N - 1);
        end
      end
      stalled   = pwr_valid && !pwr_ready;
      hold_data = pwr_data;
      hold_bin  = pwr_bin;
      hold_last = pwr_last;
      if (frame_clr) begin
        q.delete();
        m_cnt   = 0;
        stalled = 0;
      end else begin
        if (pwr_valid && pwr_ready && q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          fr[e.bin] = e.pwr;
          if (e.bin == N - 1) begin
            pk_bin  = frame_argmax();
            pk_pwr  = fr[pk_bin];
            pk_pend = 1;
          end
        end
        if (in_valid && in_ready) begin
          logic signed [15:0] re;
          logic signed [15:0] im;
          longint p;
          exp_t e;
          re = in_data[31:16];
          im = in_data[15:0];
          p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
          e.pwr = p[31:0];
          e.bin = m_cnt;
          q.push_back(e);
          m_cnt = (m_cnt + 1) % N;
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send_bin(input logic signed [15:0] re, input logic signed [15:0] im);
    bit hs = 0;
    in_valid = 1'b1;
    in_data  = {re, im};
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", hs, 1);
  endtask

  task automatic wait_peak(input string name, input int b, input longint p);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (peak_valid) seen = 1;
    end
    check({name, "_seen"}, seen, 1);
    if (seen) begin
      check({name, "_bin"}, peak_bin, b);
      check({name, "_pwr"}, peak_pwr, p);
    end
  endtask

  bit bp_done = 0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_pwr_valid", pwr_valid, 0);
    check("rst_pwr_data", pwr_data, 0);
    check("rst_pwr_bin", pwr_bin, 0);
    check("rst_pwr_last", pwr_last, 0);
    check("rst_peak_valid", peak_valid, 0);
    check("rst_peak_bin", peak_bin, 0);
    check("rst_peak_pwr", peak_pwr, 0);

    // Single bin and two-cycle latency
    @(posedge clk); #1;
    send_bin(16'sd3, -16'sd4);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", pwr_valid, 0);
    @(negedge clk);
    check("lat_valid", pwr_valid, 1);
    check("single_pwr", pwr_data, 25);
    check("single_bin", pwr_bin, 0);

    // Most negative inputs
    @(posedge clk); #1;
    send_bin(-16'sd32768, -16'sd32768);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("extreme_pwr", pwr_data, 32'h8000_0000);
    check("extreme_bin", pwr_bin, 1);
    @(posedge clk); #1;
    for (int b = 2; b < N; b++) send_bin(16'sd0, 16'sd0);
    in_valid = 1'b0;
    wait_peak("extreme_peak", 1, 32'h8000_0000);

    // DC is largest but skipped; bin 9 wins
    @(posedge clk); #1;
    for (int b = 0; b < N; b++) begin
      if (b == 0) send_bin(16'sd30, 16'sd10);
      else if (b == 9) send_bin(16'sd20, 16'sd10);
      else send_bin(16'sd3, 16'sd1);
    end
    in_valid = 1'b0;
    wait_peak("frame_peak", 9, 500);

    // Tie between bins 4 and 7 keeps the lower bin
    @(posedge clk); #1;
    for (int b = 0; b < N; b++) begin
      if (b == 4 || b == 7) send_bin(16'sd14, 16'sd2);
      else send_bin(16'sd3, 16'sd1);
    end
    in_valid = 1'b0;
    wait_peak("tie_peak", 4, 200);

    // Random backpressure over three continuous frames
    @(posedge clk); #1;
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int b = 0; b < N; b++)
            send_bin(16'($urandom), 16'($urandom));
        in_valid = 1'b0;
        bp_done  = 1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          pwr_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    pwr_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_drain_empty", q.size(), 0);

    // Flush after five accepted bins
    @(posedge clk); #1;
    for (int b = 0; b < 5; b++) send_bin(16'(b + 1), 16'sd0);
    frame_clr = 1'b1;
    in_data   = {16'sd7, 16'sd7};
    @(negedge clk);
    check("clr_ready", in_ready, 0);
    @(posedge clk); #1;
    frame_clr = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("clr_flush_valid", pwr_valid, 0);
    @(posedge clk); #1;
    send_bin(16'sd6, 16'sd8);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("clr_restart_valid", pwr_valid, 1);
    check("clr_restart_bin", pwr_bin, 0);
    check("clr_restart_pwr", pwr_data, 100);
    @(posedge clk); #1;
    for (int b = 1; b < N; b++) send_bin(16'sd1, 16'sd1);
    in_valid = 1'b0;
    wait_peak("clr_frame_peak", 1, 2);

    // Reset in the middle of a frame discards it
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) send_bin(16'sd5, 16'sd5);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_pwr_valid", pwr_valid, 0);
    check("mid_rst_peak_bin", peak_bin, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int b = 0; b < N; b++) send_bin(16'sd2, 16'sd0);
    in_valid = 1'b0;
    wait_peak("post_rst_peak", 1, 4);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
